// File: rtl/operand_stage_if.sv
// Issue bus from fetch/decode into the operand stage: decoded fields plus valid/ready handshake.
interface operand_stage_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_com;
    logic [2:0]   in_rd;
    logic [2:0]   in_rs;
    logic [2:0]   in_rt;
    logic         in_use_imm;
    logic [W-1:0] in_imm;
    logic         in_wen;
    logic         in_is_load;

    modport master (
        output in_valid, in_com, in_rd, in_rs, in_rt, in_use_imm, in_imm, in_wen, in_is_load,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_com, in_rd, in_rs, in_rt, in_use_imm, in_imm, in_wen, in_is_load,
        output in_ready
    );
endinterface

// File: rtl/operand_stage.sv
// Decode/issue stage: register file, EX/MEM/WB operand forwarding, load-use stall
// and the ID/EX pipeline register feeding the ALU.
module operand_stage #(
    parameter int NREG = 8,
    parameter int W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    operand_stage_if.slave issue,
    input  logic          flush,
    input  logic [W-1:0]  ex_result,
    input  logic          mem_valid,
    input  logic          mem_wen,
    input  logic [2:0]    mem_rd,
    input  logic [W-1:0]  mem_data,
    input  logic          wb_wen,
    input  logic [2:0]    wb_rd,
    input  logic [W-1:0]  wb_data,
    output logic          ex_valid,
    output logic [W-1:0]  ex_ina,
    output logic [W-1:0]  ex_inb,
    output logic [2:0]    ex_com,
    output logic [2:0]    ex_rd,
    output logic          ex_wen,
    output logic          ex_is_load
);

    logic [W-1:0] rf_reg [NREG];

    logic         ex_valid_reg,   ex_valid_next;
    logic [W-1:0] ex_ina_reg,     ex_ina_next;
    logic [W-1:0] ex_inb_reg,     ex_inb_next;
    logic [2:0]   ex_com_reg,     ex_com_next;
    logic [2:0]   ex_rd_reg,      ex_rd_next;
    logic         ex_wen_reg,     ex_wen_next;
    logic         ex_is_load_reg, ex_is_load_next;

    logic [2:0]   src [2];
    logic         load_use;
    logic         do_issue;
    logic [W-1:0] opb_val;

    // r0 is never written; its storage stays zero and reads are forced to zero anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (wb_wen && (wb_rd != 3'd0)) begin
            rf_reg[wb_rd] <= wb_data;
        end
    end

    assign src[0] = issue.in_rs;
    assign src[1] = issue.in_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [W-1:0] val;

            // A load sitting in EX has no data yet; the hazard stall covers that case.
            always_comb begin
                val = rf_reg[src[gi]];
                if (src[gi] == 3'd0) begin
                    val = '0;
                end else if (ex_valid_reg && ex_wen_reg && !ex_is_load_reg && (ex_rd_reg == src[gi])) begin
                    val = ex_result;
                end else if (mem_valid && mem_wen && (mem_rd == src[gi])) begin
                    val = mem_data;
                end else if (wb_wen && (wb_rd == src[gi])) begin
                    val = wb_data;
                end
            end
        end
    endgenerate

    assign load_use = issue.in_valid && ex_valid_reg && ex_is_load_reg && ex_wen_reg
                   && (ex_rd_reg != 3'd0)
                   && ((ex_rd_reg == issue.in_rs) || (!issue.in_use_imm && (ex_rd_reg == issue.in_rt)));

    assign issue.in_ready = !load_use || flush;
    assign do_issue       = issue.in_valid && issue.in_ready && !flush;
    assign opb_val        = issue.in_use_imm ? issue.in_imm : g_src[1].val;

    // Stalls, flushes and idle cycles all collapse to the all-zero bubble.
    always_comb begin
        ex_valid_next   = 1'b0;
        ex_ina_next     = '0;
        ex_inb_next     = '0;
        ex_com_next     = 3'd0;
        ex_rd_next      = 3'd0;
        ex_wen_next     = 1'b0;
        ex_is_load_next = 1'b0;
        if (do_issue) begin
            ex_valid_next   = 1'b1;
            ex_ina_next     = g_src[0].val;
            ex_inb_next     = opb_val;
            ex_com_next     = issue.in_com;
            ex_rd_next      = issue.in_rd;
            ex_wen_next     = issue.in_wen;
            ex_is_load_next = issue.in_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg   <= 1'b0;
            ex_ina_reg     <= '0;
            ex_inb_reg     <= '0;
            ex_com_reg     <= 3'd0;
            ex_rd_reg      <= 3'd0;
            ex_wen_reg     <= 1'b0;
            ex_is_load_reg <= 1'b0;
        end else begin
            ex_valid_reg   <= ex_valid_next;
            ex_ina_reg     <= ex_ina_next;
            ex_inb_reg     <= ex_inb_next;
            ex_com_reg     <= ex_com_next;
            ex_rd_reg      <= ex_rd_next;
            ex_wen_reg     <= ex_wen_next;
            ex_is_load_reg <= ex_is_load_next;
        end
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_ina     = ex_ina_reg;
    assign ex_inb     = ex_inb_reg;
    assign ex_com     = ex_com_reg;
    assign ex_rd      = ex_rd_reg;
    assign ex_wen     = ex_wen_reg;
    assign ex_is_load = ex_is_load_reg;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: forwarding priority, load-use stall, r0, flush and async reset.
module tb_operand_stage;

    localparam int W = 16;
    localparam logic [2:0] C_OR  = 3'd3;
    localparam logic [2:0] C_ADD = 3'd6;
    localparam logic [2:0] C_SUB = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [W-1:0] ex_result;
    logic         mem_valid, mem_wen;
    logic [2:0]   mem_rd;
    logic [W-1:0] mem_data;
    logic         wb_wen;
    logic [2:0]   wb_rd;
    logic [W-1:0] wb_data;
    logic         ex_valid, ex_wen, ex_is_load;
    logic [W-1:0] ex_ina, ex_inb;
    logic [2:0]   ex_com, ex_rd;

    int vectors = 0;
    int miscompares = 0;

    operand_stage_if #(.W(W)) bus ();

    operand_stage #(.NREG(8), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (bus),
        .flush      (flush),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_wen    (mem_wen),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_wen     (wb_wen),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .ex_valid   (ex_valid),
        .ex_ina     (ex_ina),
        .ex_inb     (ex_inb),
        .ex_com     (ex_com),
        .ex_rd      (ex_rd),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.in_valid   = 1'b0;
        bus.in_com     = 3'd0;
        bus.in_rd      = 3'd0;
        bus.in_rs      = 3'd0;
        bus.in_rt      = 3'd0;
        bus.in_use_imm = 1'b0;
        bus.in_imm     = '0;
        bus.in_wen     = 1'b0;
        bus.in_is_load = 1'b0;
        flush     = 1'b0;
        ex_result = '0;
        mem_valid = 1'b0;
        mem_wen   = 1'b0;
        mem_rd    = 3'd0;
        mem_data  = '0;
        wb_wen    = 1'b0;
        wb_rd     = 3'd0;
        wb_data   = '0;
    endtask

    task automatic instr(input logic [2:0] com, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic wen, input logic ld);
        bus.in_valid   = 1'b1;
        bus.in_com     = com;
        bus.in_rd      = rd;
        bus.in_rs      = rs;
        bus.in_rt      = rt;
        bus.in_wen     = wen;
        bus.in_is_load = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {15'd0, bus.in_ready}, 16'd1);
        chk("rst_valid", {15'd0, ex_valid}, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // WB bypass: r3 written and read in the same cycle
        clr(); instr(C_ADD, 3'd1, 3'd3, 3'd0, 1'b0, 1'b0);
        wb_wen = 1'b1; wb_rd = 3'd3; wb_data = 16'h1234;
        tick();
        chk("wbbyp_ina", ex_ina, 16'h1234);
        chk("wbbyp_inb", ex_inb, 16'h0000);
        chk("wbbyp_com", {13'd0, ex_com}, {13'd0, C_ADD});
        chk("wbbyp_valid", {15'd0, ex_valid}, 16'd1);

        // Register file holds r3 after the write
        clr(); instr(C_ADD, 3'd0, 3'd3, 3'd3, 1'b0, 1'b0);
        tick();
        chk("rf_r3_ina", ex_ina, 16'h1234);
        chk("rf_r3_inb", ex_inb, 16'h1234);

        // Producer of r2 into EX
        clr(); instr(C_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0);
        tick();
        chk("prod_rd", {13'd0, ex_rd}, 16'd2);
        // EX beats MEM beats WB
        clr(); instr(C_ADD, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0);
        ex_result = 16'h00AA;
        mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 3'd2; mem_data = 16'h00BB;
        wb_wen = 1'b1; wb_rd = 3'd2; wb_data = 16'h00CC;
        tick();
        chk("prio_ex", ex_ina, 16'h00AA);
        // EX no longer writes: MEM wins over WB
        clr(); instr(C_ADD, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0);
        ex_result = 16'h00AA;
        mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 3'd2; mem_data = 16'h00BB;
        wb_wen = 1'b1; wb_rd = 3'd2; wb_data = 16'h00DD;
        tick();
        chk("prio_mem", ex_ina, 16'h00BB);
        // MEM marked invalid: WB bypass
        clr(); instr(C_ADD, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0);
        mem_wen = 1'b1; mem_rd = 3'd2; mem_data = 16'h00BB;
        wb_wen = 1'b1; wb_rd = 3'd2; wb_data = 16'h00EE;
        tick();
        chk("prio_wb", ex_inb, 16'h00EE);

        // EX entry is a load to r2: stall one cycle, then take MEM load data
        clr(); instr(C_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 1'b1);
        tick();
        chk("ld_is_load", {15'd0, ex_is_load}, 16'd1);
        clr(); instr(C_ADD, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0);
        ex_result = 16'h00AA;
        #1;
        chk("ldprio_ready", {15'd0, bus.in_ready}, 16'd0);
        tick();
        chk("ldprio_bubble_valid", {15'd0, ex_valid}, 16'd0);
        chk("ldprio_bubble_ina", ex_ina, 16'h0000);
        mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 3'd2; mem_data = 16'h5A5A;
        #1;
        chk("ldprio_ready2", {15'd0, bus.in_ready}, 16'd1);
        tick();
        chk("ldprio_ina", ex_ina, 16'h5A5A);
        chk("ldprio_valid", {15'd0, ex_valid}, 16'd1);

        // Load r4 then SUB rt=4: one bubble, then MEM data on inb
        clr(); instr(C_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 1'b1);
        tick();
        clr(); instr(C_SUB, 3'd1, 3'd0, 3'd4, 1'b1, 1'b0);
        #1;
        chk("lu_ready", {15'd0, bus.in_ready}, 16'd0);
        tick();
        chk("lu_bubble_valid", {15'd0, ex_valid}, 16'd0);
        chk("lu_bubble_wen", {15'd0, ex_wen}, 16'd0);
        mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 3'd4; mem_data = 16'h0F0F;
        tick();
        chk("lu_inb", ex_inb, 16'h0F0F);
        chk("lu_valid", {15'd0, ex_valid}, 16'd1);
        chk("lu_com", {13'd0, ex_com}, {13'd0, C_SUB});

        // Same with immediate: no stall
        clr(); instr(C_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 1'b1);
        tick();
        clr(); instr(C_SUB, 3'd1, 3'd0, 3'd4, 1'b1, 1'b0);
        bus.in_use_imm = 1'b1; bus.in_imm = 16'h0007;
        #1;
        chk("imm_ready", {15'd0, bus.in_ready}, 16'd1);
        tick();
        chk("imm_inb", ex_inb, 16'h0007);
        chk("imm_valid", {15'd0, ex_valid}, 16'd1);

        // r0: EX load with rd=0, WB to r0, MEM rd=0 -- all ignored
        clr(); instr(C_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
        tick();
        clr(); instr(C_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        ex_result = 16'h1111;
        mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 3'd0; mem_data = 16'h2222;
        wb_wen = 1'b1; wb_rd = 3'd0; wb_data = 16'hFFFF;
        #1;
        chk("r0_ready", {15'd0, bus.in_ready}, 16'd1);
        tick();
        chk("r0_ina", ex_ina, 16'h0000);
        chk("r0_inb", ex_inb, 16'h0000);
        clr(); instr(C_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        chk("r0_after_wb", ex_ina, 16'h0000);

        // Flush during a load-use stall
        clr(); instr(C_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 1'b1);
        tick();
        clr(); instr(C_ADD, 3'd6, 3'd5, 3'd0, 1'b1, 1'b0);
        #1;
        chk("fl_stall_ready", {15'd0, bus.in_ready}, 16'd0);
        flush = 1'b1;
        #1;
        chk("fl_ready", {15'd0, bus.in_ready}, 16'd1);
        tick();
        chk("fl_valid", {15'd0, ex_valid}, 16'd0);
        chk("fl_rd", {13'd0, ex_rd}, 16'd0);
        clr(); instr(C_OR, 3'd1, 3'd3, 3'd0, 1'b1, 1'b0);
        tick();
        chk("post_fl_valid", {15'd0, ex_valid}, 16'd1);
        chk("post_fl_com", {13'd0, ex_com}, {13'd0, C_OR});
        chk("post_fl_ina", ex_ina, 16'h1234);

        // Asynchronous reset mid-run with a live ID/EX entry
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {15'd0, ex_valid}, 16'd0);
        chk("arst_ina", ex_ina, 16'h0000);
        chk("arst_com", {13'd0, ex_com}, 16'd0);
        chk("arst_rd", {13'd0, ex_rd}, 16'd0);
        chk("arst_wen", {15'd0, ex_wen}, 16'd0);
        clr();
        tick();
        rst_n = 1'b1;
        clr(); instr(C_ADD, 3'd1, 3'd3, 3'd2, 1'b1, 1'b0);
        tick();
        chk("arst_r3", ex_ina, 16'h0000);
        chk("arst_r2", ex_inb, 16'h0000);
        chk("arst_issue_valid", {15'd0, ex_valid}, 16'd1);
        clr(); instr(C_ADD, 3'd0, 3'd5, 3'd4, 1'b0, 1'b0);
        tick();
        chk("arst_r5", ex_ina, 16'h0000);
        chk("arst_r4", ex_inb, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
# operand_stage

Decode/issue stage directly upstream of the 16-bit ALU in the pipelined CPU. It holds the 8×16 register file, reads two source operands, and resolves RAW hazards by forwarding from the EX, MEM and WB stages. It inserts a one-cycle bubble on load-use hazards and registers `ina`, `inb` and `com` into the ID/EX pipeline register that drives the ALU.

## Interface
Parameters:
- `NREG`, 8: register count; register index width is 3.
- `W`, 16: datapath width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  decoded instruction present from fetch.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_com`  in  3  ALU command (THA/THB/AND/OR/SL/SR/ADD/SUB encoding).
- `in_rd`, `in_rs`, `in_rt`  in  3 each  destination and source register indices.
- `in_use_imm`  in  1  inb is sourced from `in_imm` instead of rt.
- `in_imm`  in  W  immediate, already extended.
- `in_wen`  in  1  instruction writes rd.
- `in_is_load`  in  1  rd is written from memory in MEM, not by the ALU.
- `flush`  in  1  kill the instruction being issued this cycle.
- `ex_result`  in  W  combinational ALU output for the instruction now in ID/EX.
- `mem_valid`, `mem_wen`  in  1 each  MEM stage holds a register-writing instruction.
- `mem_rd`  in  3  MEM stage destination.
- `mem_data`  in  W  MEM stage result (ALU result or load data).
- `wb_wen`  in  1  write-back enable.
- `wb_rd`  in  3  write-back index.
- `wb_data`  in  W  write-back data.
- `ex_valid`  out  1  ID/EX register holds a live instruction.
- `ex_ina`, `ex_inb`  out  W  ALU operands.
- `ex_com`  out  3  ALU command.
- `ex_rd`  out  3  destination passed down the pipe.
- `ex_wen`  out  1  write enable passed down the pipe.
- `ex_is_load`  out  1  load flag passed down the pipe.

## Operation
- Register file: r0 always reads 0, and writes to r0 are ignored. Write occurs on the clock edge when `wb_wen` is high and `wb_rd != 0`.
- Operand A value: rs. Operand B value: `in_imm` if `in_use_imm` is high, otherwise rt.
- Forwarding is applied per source register and only when the index is nonzero. Priority, first match wins:
  1. EX: `ex_valid & ex_wen & !ex_is_load & ex_rd == src` selects `ex_result`.
  2. MEM: `mem_valid & mem_wen & mem_rd == src` selects `mem_data`.
  3. WB: `wb_wen & wb_rd == src` selects `wb_data` (write-through bypass).
  4. Otherwise the register file value is used.
- Load-use hazard: `in_valid & ex_valid & ex_is_load & ex_wen & ex_rd != 0`, and `ex_rd` equals rs, or equals rt while `in_use_imm = 0`.
  - On a hazard: `in_ready = 0`, and the ID/EX register loads a bubble (`ex_valid = 0`, `ex_wen = 0`).
  - Next cycle the load is in MEM and the value forwards from `mem_data`.
- `in_ready = !hazard | flush`.
- Flush has priority over the hazard. During flush the input is consumed and discarded, `in_ready = 1`, and a bubble is loaded into ID/EX.
- Issue (`in_valid & in_ready & !flush`): the ID/EX register loads the selected operands, `in_com`, `in_rd`, `in_wen` and `in_is_load`, and sets `ex_valid = 1`.
- With `in_valid = 0` and no flush, a bubble is loaded.
- Bubble encoding: all `ex_*` outputs are 0.

## Timing
- Reset (asynchronous, while `rst_n = 0`): all registers r1..r7 = 0; `ex_valid`, `ex_ina`, `ex_inb`, `ex_com`, `ex_rd`, `ex_wen`, `ex_is_load` = 0.
- `in_ready` is combinational; it is 1 during reset and has no dependency on `ex_result` timing beyond the hazard decode.
- Latency: one cycle from the accepted input to the `ex_*` outputs.
- Register file write to dependent read in the same cycle: visible via the WB bypass, with 0-cycle penalty.
- Load followed immediately by a dependent instruction: exactly one bubble, then issue with `mem_data`.
- A hazard on both rs and rt against the same load still costs a single bubble.
- Reset deasserted mid-stream: the first valid instruction after release issues normally from zeroed registers.

## Test plan
- **Reset:** assert `rst_n = 0` mid-run with `ex_valid = 1` -> all `ex_*` outputs = 0 immediately; reading r1..r7 afterwards returns 0.
- **WB bypass:** WB writes r3 = 0x1234 in the same cycle that an instruction with rs = 3, rt = 0, ADD is issued -> `ex_ina = 0x1234`, `ex_inb = 0`, `ex_com = ADD`.
- **Priority:** EX (r2 = 0x00AA via `ex_result`), MEM (r2 = 0x00BB) and WB (r2 = 0x00CC) all match rs = 2 -> `ex_ina = 0x00AA`; with the EX entry marked as a load, the instruction stalls for one cycle and then issues with `ex_ina` = the MEM load value on r2 in the following cycle.
- **Load-use:** load r4 followed by SUB using rt = 4 -> `in_ready = 0` for one cycle with a bubble in ID/EX; the next cycle has `ex_inb = mem_data`, `ex_valid = 1`. The same sequence with `in_use_imm = 1` and `in_imm = 0x0007` -> no stall, `ex_inb = 0x0007`.
- **r0:** WB writes r0 = 0xFFFF and EX has `ex_rd = 0`, `ex_wen = 1` -> a read of rs = 0 gives `ex_ina = 0`, with no forwarding and no stall.
- **Flush:** flush during a load-use stall -> `in_ready = 1`, the instruction is dropped and `ex_valid = 0` next cycle; the following instruction issues normally.
